// File: rtl/can_tx_loader.sv
`default_nettype none
// ============================================================================
// Module   : can_tx_loader
// Purpose  : Polls a memory-mapped setting word. When its GO bit is set, the
//            block reads two 32-bit payload words from the data mailbox and
//            hands one frame to a CAN transmitter. Once the transmitter has
//            finished, it writes the setting word back with GO cleared.
//            Each handshake wait is bounded by a timeout that raises a sticky
//            error flag.
// Ports    : clk_i / rst_i       - clock, asynchronous active-high reset
//            rd_en, addr_rd      - one-cycle read request and its address
//            data_rd, rd_done    - read data, valid with the rd_done pulse
//            rd_busy             - read port cannot accept a request
//            wr_en, addr_wr,
//            data_wr             - one-cycle write request, address and data
//            wr_done, wr_busy    - write completion pulse, write port busy
//            tx_data_o, tx_dlc_o - frame payload and byte length
//            tx_send_o           - one-cycle transmit request
//            tx_busy_i           - transmitter busy
//            busy_o              - FSM is outside IDLE
//            err_o               - sticky timeout flag
//            frames_sent_o       - completed frame count (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module can_tx_loader #(
  parameter int                    ADDR_WIDTH     = 20,
  parameter int                    DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] ADDR_DATA      = 20'hA0001,
  parameter logic [ADDR_WIDTH-1:0] ADDR_SETTING   = 20'hA0002,
  parameter int                    POLL_CYCLES    = 1000,
  parameter int                    TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] addr_rd,
  input  logic [DATA_WIDTH-1:0] data_rd,
  input  logic                  rd_done,
  input  logic                  rd_busy,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] addr_wr,
  output logic [DATA_WIDTH-1:0] data_wr,
  input  logic                  wr_done,
  input  logic                  wr_busy,
  output logic [63:0]           tx_data_o,
  output logic [3:0]            tx_dlc_o,
  output logic                  tx_send_o,
  input  logic                  tx_busy_i,
  output logic                  busy_o,
  output logic                  err_o,
  output logic [15:0]           frames_sent_o
);

  localparam int PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES + 1) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_RD_SET    = 4'd1,
    S_WT_SET    = 4'd2,
    S_RD_HI     = 4'd3,
    S_WT_HI     = 4'd4,
    S_RD_LO     = 4'd5,
    S_WT_LO     = 4'd6,
    S_WT_TXIDLE = 4'd7,
    S_SEND      = 4'd8,
    S_WT_TXBUSY = 4'd9,
    S_WT_TXDONE = 4'd10,
    S_CLR       = 4'd11,
    S_WT_CLR    = 4'd12
  } state_t;

  state_t                  state_q, state_d;
  logic [PW-1:0]           poll_q, poll_d;
  logic [TW-1:0]           tmr_q, tmr_d;
  logic [DATA_WIDTH-1:0]   set_q, set_d;
  logic [ADDR_WIDTH-1:0]   addr_rd_q, addr_rd_d;
  logic [ADDR_WIDTH-1:0]   addr_wr_q, addr_wr_d;
  logic [DATA_WIDTH-1:0]   data_wr_q, data_wr_d;
  logic [63:0]             tx_data_q, tx_data_d;
  logic [3:0]              tx_dlc_q, tx_dlc_d;
  logic                    err_q, err_d;
  logic [15:0]             frames_q, frames_d;
  logic                    tmo;

  // Expiry of the per-state wait budget; only acted upon in wait states.
  assign tmo = (tmr_q == TMO_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      poll_q    <= '0;
      tmr_q     <= '0;
      set_q     <= '0;
      addr_rd_q <= '0;
      addr_wr_q <= '0;
      data_wr_q <= '0;
      tx_data_q <= '0;
      tx_dlc_q  <= '0;
      err_q     <= 1'b0;
      frames_q  <= '0;
    end else begin
      state_q   <= state_d;
      poll_q    <= poll_d;
      tmr_q     <= tmr_d;
      set_q     <= set_d;
      addr_rd_q <= addr_rd_d;
      addr_wr_q <= addr_wr_d;
      data_wr_q <= data_wr_d;
      tx_data_q <= tx_data_d;
      tx_dlc_q  <= tx_dlc_d;
      err_q     <= err_d;
      frames_q  <= frames_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    poll_d    = '0;
    set_d     = set_q;
    addr_rd_d = addr_rd_q;
    addr_wr_d = addr_wr_q;
    data_wr_d = data_wr_q;
    tx_data_d = tx_data_q;
    tx_dlc_d  = tx_dlc_q;
    err_d     = err_q;
    frames_d  = frames_q;
    rd_en     = 1'b0;
    wr_en     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (poll_q == POLL_LAST) begin
          state_d   = S_RD_SET;
          addr_rd_d = ADDR_SETTING;
        end else begin
          poll_d = poll_q + PW'(1);
        end
      end

      // Request strobes are combinational so they are issued in the very
      // cycle the port is seen idle; the address is already registered.
      S_RD_SET: begin
        if (!rd_busy) begin
          rd_en   = 1'b1;
          state_d = S_WT_SET;
        end
      end

      S_WT_SET: begin
        if (rd_done) begin
          if (data_rd[31]) begin
            set_d     = data_rd;
            addr_rd_d = ADDR_DATA;
            state_d   = S_RD_HI;
          end else begin
            state_d = S_IDLE;
          end
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end

      S_RD_HI: begin
        if (!rd_busy) begin
          rd_en   = 1'b1;
          state_d = S_WT_HI;
        end
      end

      S_WT_HI: begin
        if (rd_done) begin
          tx_data_d[63:32] = data_rd;
          addr_rd_d        = ADDR_DATA;
          state_d          = S_RD_LO;
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end

      S_RD_LO: begin
        if (!rd_busy) begin
          rd_en   = 1'b1;
          state_d = S_WT_LO;
        end
      end

      // The length is published together with the low word so that both
      // frame outputs only change after the next frame's first data read.
      S_WT_LO: begin
        if (rd_done) begin
          tx_data_d[31:0] = data_rd;
          tx_dlc_d        = (set_q[3:0] > 4'd8) ? 4'd8 : set_q[3:0];
          state_d         = S_WT_TXIDLE;
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end

      S_WT_TXIDLE: begin
        if (!tx_busy_i) begin
          state_d = S_SEND;
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end

      S_SEND: begin
        state_d = S_WT_TXBUSY;
      end

      S_WT_TXBUSY: begin
        if (tx_busy_i) begin
          state_d = S_WT_TXDONE;
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end

      S_WT_TXDONE: begin
        if (!tx_busy_i) begin
          addr_wr_d = ADDR_SETTING;
          data_wr_d = {1'b0, set_q[DATA_WIDTH-2:0]};
          state_d   = S_CLR;
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end

      S_CLR: begin
        if (!wr_busy) begin
          wr_en   = 1'b1;
          state_d = S_WT_CLR;
        end
      end

      S_WT_CLR: begin
        if (wr_done) begin
          frames_d = frames_q + 16'd1;
          state_d  = S_IDLE;
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Timer restarts on every state change and saturates otherwise, so a
    // long stall in a request state cannot wrap it into a false expiry.
    if (state_d != state_q) begin
      tmr_d = '0;
    end else if (!tmo) begin
      tmr_d = tmr_q + TW'(1);
    end else begin
      tmr_d = tmr_q;
    end
  end

  assign addr_rd       = addr_rd_q;
  assign addr_wr       = addr_wr_q;
  assign data_wr       = data_wr_q;
  assign tx_data_o     = tx_data_q;
  assign tx_dlc_o      = tx_dlc_q;
  assign tx_send_o     = (state_q == S_SEND);
  assign busy_o        = (state_q != S_IDLE);
  assign err_o         = err_q;
  assign frames_sent_o = frames_q;

endmodule
`default_nettype wire

// File: tb/tb_can_tx_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_can_tx_loader
// Purpose  : Self-checking bench for can_tx_loader. A behavioural memory and
//            CAN transmitter surround the design; a table of frame vectors
//            is applied in a loop, followed by hand-written sequences for GO
//            clear, backpressure, timeout and mid-frame reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_can_tx_loader;

  localparam int          POLL   = 10;
  localparam int          TMO    = 64;
  localparam logic [19:0] A_DATA = 20'hA0001;
  localparam logic [19:0] A_SET  = 20'hA0002;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_en;
  logic [19:0] addr_rd;
  logic [31:0] data_rd = '0;
  logic        rd_done = 1'b0;
  logic        rd_busy = 1'b0;
  logic        wr_en;
  logic [19:0] addr_wr;
  logic [31:0] data_wr;
  logic        wr_done = 1'b0;
  logic        wr_busy = 1'b0;
  logic [63:0] tx_data;
  logic [3:0]  tx_dlc;
  logic        tx_send;
  logic        tx_busy = 1'b0;
  logic        busy;
  logic        err;
  logic [15:0] frames;

  always #5 clk = ~clk;

  can_tx_loader #(
    .ADDR_WIDTH    (20),
    .DATA_WIDTH    (32),
    .ADDR_DATA     (A_DATA),
    .ADDR_SETTING  (A_SET),
    .POLL_CYCLES   (POLL),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .rd_en        (rd_en),
    .addr_rd      (addr_rd),
    .data_rd      (data_rd),
    .rd_done      (rd_done),
    .rd_busy      (rd_busy),
    .wr_en        (wr_en),
    .addr_wr      (addr_wr),
    .data_wr      (data_wr),
    .wr_done      (wr_done),
    .wr_busy      (wr_busy),
    .tx_data_o    (tx_data),
    .tx_dlc_o     (tx_dlc),
    .tx_send_o    (tx_send),
    .tx_busy_i    (tx_busy),
    .busy_o       (busy),
    .err_o        (err),
    .frames_sent_o(frames)
  );

  // ---------------- memory / transmitter model state ----------------------
  logic [31:0] mem_set = '0;
  logic [31:0] mbox [2];
  int          didx = 0;
  logic        rd_pend = 1'b0;
  int          rd_cnt = 0;
  logic [19:0] rd_addr = '0;
  logic        wr_pend = 1'b0;
  int          wr_lat = 0;
  logic        drop_hi = 1'b0;
  logic        tx_hold = 1'b0;
  int          tx_len = 5;
  int          tx_cnt = 0;
  int          cyc = 0;
  int          rd_any_cnt = 0, set_rd_cnt = 0, data_rd_cnt = 0;
  int          send_cnt = 0, wr_cnt = 0, viol_cnt = 0;
  int          set_rd_cyc [8];
  int          drop_cyc = 0, err_cyc = 0;
  logic        err_prev = 1'b0;
  logic [19:0] last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Model runs just after the falling edge: it samples settled DUT outputs
  // and drives responses well before the next rising edge.
  always begin
    @(negedge clk);
    #1;
    cyc++;
    if (tx_cnt > 0) tx_cnt--;
    if (rst) begin
      rd_pend = 1'b0;
      wr_pend = 1'b0;
      rd_done = 1'b0;
      wr_done = 1'b0;
    end else begin
      if (rd_en && rd_busy) viol_cnt++;
      if (wr_en && wr_busy) viol_cnt++;
      if (rd_en && wr_en) viol_cnt++;
      if (tx_send && tx_busy) viol_cnt++;
      if ((rd_en || wr_en) && (rd_pend || wr_pend)) viol_cnt++;
      if (err && !err_prev) err_cyc = cyc;

      rd_done = 1'b0;
      if (rd_pend) begin
        if (rd_cnt == 0) begin
          rd_done = 1'b1;
          rd_pend = 1'b0;
          if (rd_addr == A_SET) begin
            data_rd = mem_set;
          end else begin
            data_rd = mbox[didx];
            didx    = 1 - didx;
          end
        end else begin
          rd_cnt--;
        end
      end
      if (rd_en) begin
        rd_any_cnt++;
        if (addr_rd == A_SET) begin
          if (set_rd_cnt < 8) set_rd_cyc[set_rd_cnt] = cyc;
          set_rd_cnt++;
          rd_pend = 1'b1;
          rd_cnt  = 1;
          rd_addr = addr_rd;
        end else begin
          data_rd_cnt++;
          if (drop_hi) begin
            drop_hi  = 1'b0;
            drop_cyc = cyc;
          end else begin
            rd_pend = 1'b1;
            rd_cnt  = 1;
            rd_addr = addr_rd;
          end
        end
      end

      wr_done = 1'b0;
      if (wr_pend) begin
        if (wr_lat == 0) begin
          wr_done = 1'b1;
          wr_pend = 1'b0;
        end else begin
          wr_lat--;
        end
      end
      if (wr_en) begin
        wr_cnt++;
        last_wr_addr = addr_wr;
        last_wr_data = data_wr;
        if (addr_wr == A_SET) mem_set = data_wr;
        wr_pend = 1'b1;
        wr_lat  = 1;
      end

      if (tx_send) begin
        send_cnt++;
        tx_cnt = tx_len;
      end
    end
    tx_busy  = tx_hold || (tx_cnt != 0);
    err_prev = err;
  end

  // ---------------- helpers ----------------------------------------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic clear_counts();
    rd_any_cnt  = 0;
    set_rd_cnt  = 0;
    data_rd_cnt = 0;
    send_cnt    = 0;
    wr_cnt      = 0;
    viol_cnt    = 0;
  endtask

  task automatic wait_frames(input logic [15:0] tgt, input int budget, input string name);
    int n;
    n = 0;
    while (frames !== tgt && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done"}, 64'(frames), 64'(tgt));
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_ctrl"}, 64'({rd_en, wr_en, tx_send, busy, err}), 64'd0);
    chk({tag, "_addr"}, 64'({addr_rd, addr_wr}), 64'd0);
    chk({tag, "_wdata"}, 64'(data_wr), 64'd0);
    chk({tag, "_txdata"}, tx_data, 64'd0);
    chk({tag, "_dlc_frames"}, 64'({tx_dlc, frames}), 64'd0);
  endtask

  typedef struct {
    logic [31:0] setting;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [63:0] exp_data;
    logic [3:0]  exp_dlc;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs [5];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ---------------------------------------------
  initial begin
    int n;
    vecs[0] = '{32'h80000008, 32'h31323334, 32'h35363738, 64'h3132333435363738, 4'd8, 32'h00000008};
    vecs[1] = '{32'h8000000F, 32'hA5A5A5A5, 32'h5A5A5A5A, 64'hA5A5A5A55A5A5A5A, 4'd8, 32'h0000000F};
    vecs[2] = '{32'h80000003, 32'hDEADBEEF, 32'h01234567, 64'hDEADBEEF01234567, 4'd3, 32'h00000003};
    vecs[3] = '{32'hC0F00090, 32'h00000000, 32'hFFFFFFFF, 64'h00000000FFFFFFFF, 4'd0, 32'h40F00090};
    vecs[4] = '{32'h80000009, 32'h12345678, 32'h9ABCDEF0, 64'h123456789ABCDEF0, 4'd8, 32'h00000009};

    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;

    // Table-driven frames
    for (int i = 0; i < 5; i++) begin
      mbox[0] = vecs[i].hi;
      mbox[1] = vecs[i].lo;
      didx    = 0;
      clear_counts();
      mem_set = vecs[i].setting;
      wait_frames(16'(i + 1), 600, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_txdata", i), tx_data, vecs[i].exp_data);
      chk($sformatf("vec%0d_dlc", i), 64'(tx_dlc), 64'(vecs[i].exp_dlc));
      chk($sformatf("vec%0d_sends", i), 64'(send_cnt), 64'd1);
      chk($sformatf("vec%0d_writes", i), 64'(wr_cnt), 64'd1);
      chk($sformatf("vec%0d_waddr", i), 64'(last_wr_addr), 64'(A_SET));
      chk($sformatf("vec%0d_wdata", i), 64'(last_wr_data), 64'(vecs[i].exp_wdata));
    end

    // GO clear: only setting polls, spaced by the poll interval
    mem_set = 32'h00000008;
    clear_counts();
    repeat (70) @(negedge clk);
    chk("goclr_polls", 64'(set_rd_cnt >= 3), 64'd1);
    chk("goclr_gap", 64'(set_rd_cyc[2] - set_rd_cyc[1]), 64'(POLL + 3));
    chk("goclr_no_data_read", 64'(data_rd_cnt), 64'd0);
    chk("goclr_no_send", 64'(send_cnt), 64'd0);
    chk("goclr_no_write", 64'(wr_cnt), 64'd0);

    // Backpressure on the read port and on the transmitter
    rd_busy = 1'b1;
    tx_hold = 1'b1;
    clear_counts();
    mbox[0] = 32'h11223344;
    mbox[1] = 32'h55667788;
    didx    = 0;
    mem_set = 32'h80000005;
    repeat (50) @(negedge clk);
    chk("bp_no_rd_while_busy", 64'(rd_any_cnt), 64'd0);
    chk("bp_stalled", 64'(busy), 64'd1);
    rd_busy = 1'b0;
    n = 0;
    while (data_rd_cnt < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_data_reads", 64'(data_rd_cnt), 64'd2);
    repeat (20) @(negedge clk);
    chk("bp_no_send_while_txbusy", 64'(send_cnt), 64'd0);
    tx_hold = 1'b0;
    wait_frames(16'd6, 300, "bp");
    chk("bp_sends", 64'(send_cnt), 64'd1);
    chk("bp_txdata", tx_data, 64'h1122334455667788);
    chk("bp_dlc", 64'(tx_dlc), 64'd5);
    chk("bp_wdata", 64'(last_wr_data), 64'h00000005);
    chk("bp_port_rules", 64'(viol_cnt), 64'd0);

    // Timeout: first high-word read is never answered
    clear_counts();
    mbox[0] = 32'hCAFEF00D;
    mbox[1] = 32'h0BADBEEF;
    didx    = 0;
    drop_hi = 1'b1;
    mem_set = 32'h80000002;
    n = 0;
    while (err !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("tmo_err", 64'(err), 64'd1);
    chk("tmo_latency", 64'(err_cyc - drop_cyc), 64'(TMO + 1));
    chk("tmo_idle", 64'(busy), 64'd0);
    chk("tmo_no_write", 64'(wr_cnt), 64'd0);
    chk("tmo_frames_kept", 64'(frames), 64'd6);
    chk("tmo_go_kept", 64'(mem_set[31]), 64'd1);
    wait_frames(16'd7, 600, "tmo_retry");
    chk("tmo_retry_txdata", tx_data, 64'hCAFEF00D0BADBEEF);
    chk("tmo_retry_sends", 64'(send_cnt), 64'd1);
    chk("tmo_err_sticky", 64'(err), 64'd1);

    // Reset while waiting for the transmitter to finish
    tx_len = 20;
    clear_counts();
    mbox[0] = 32'h0A0B0C0D;
    mbox[1] = 32'h01020304;
    didx    = 0;
    mem_set = 32'h80000004;
    n = 0;
    while (send_cnt < 1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    chk("prerst_busy", 64'(busy), 64'd1);
    chk("prerst_no_write", 64'(wr_cnt), 64'd0);
    rst = 1'b1;
    #1;
    check_reset_values("midrst");
    @(posedge clk);
    #1;
    check_reset_values("midrst_edge");
    @(negedge clk);
    rst    = 1'b0;
    tx_len = 5;
    clear_counts();
    didx = 0;
    wait_frames(16'd1, 600, "postrst");
    chk("postrst_sends", 64'(send_cnt), 64'd1);
    chk("postrst_writes", 64'(wr_cnt), 64'd1);
    chk("postrst_txdata", tx_data, 64'h0A0B0C0D01020304);
    chk("postrst_wdata", 64'(last_wr_data), 64'h00000004);
    chk("postrst_err_clear", 64'(err), 64'd0);
    chk("postrst_port_rules", 64'(viol_cnt), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/can_tx_loader.md
CAN_TX_LOADER -- requirements
Module: can_tx_loader

Interface
REQ-001 Parameters, one per line:
- ADDR_WIDTH, 20, memory address width.
- DATA_WIDTH, 32, memory data width; fixed at 32.
- ADDR_DATA, 20'hA0001, data mailbox address.
- ADDR_SETTING, 20'hA0002, setting word address.
- POLL_CYCLES, 1000, idle cycles between setting polls (>=1).
- TIMEOUT_CYCLES, 4096, maximum wait on any handshake (>=2).

REQ-002 Ports (name, direction, width, meaning), one per line:
- clk_i, in, 1, single clock.
- rst_i, in, 1, asynchronous active-high reset.
- rd_en, out, 1, one-cycle memory read request.
- addr_rd, out, ADDR_WIDTH, read address.
- data_rd, in, 32, read data; valid in the rd_done cycle.
- rd_done, in, 1, read complete pulse.
- rd_busy, in, 1, read port busy.
- wr_en, out, 1, one-cycle memory write request.
- addr_wr, out, ADDR_WIDTH, write address.
- data_wr, out, 32, write data.
- wr_done, in, 1, write complete pulse.
- wr_busy, in, 1, write port busy.
- tx_data_o, out, 64, frame payload to the CAN transmitter.
- tx_dlc_o, out, 4, frame length in bytes.
- tx_send_o, out, 1, one-cycle transmit request.
- tx_busy_i, in, 1, CAN transmitter busy.
- busy_o, out, 1, high whenever the FSM is not in IDLE.
- err_o, out, 1, sticky timeout flag.
- frames_sent_o, out, 16, count of completed frames.

REQ-003 Setting word format:
- bit31 = GO.
- bits[3:0] = DLC; values above 8 saturate to 8.
- all other bits ignored and written back as read.

Function
REQ-004 FSM states: IDLE, RD_SET, WT_SET, RD_HI, WT_HI, RD_LO, WT_LO, WT_TXIDLE, SEND, WT_TXBUSY, WT_TXDONE, CLR, WT_CLR.

REQ-005 IDLE:
- Poll counter counts to POLL_CYCLES, then moves to RD_SET.

REQ-006 Read request states (RD_*):
- Assert rd_en for exactly one cycle, only in a cycle where rd_busy=0; otherwise hold in the RD_* state.
- addr_rd = ADDR_SETTING for RD_SET, ADDR_DATA for RD_HI and RD_LO.
- addr_rd is held stable until rd_done.

REQ-007 Read wait states (WT_*):
- Capture data_rd in the rd_done cycle.
- WT_SET with GO=0 -> IDLE.
- WT_SET with GO=1 -> RD_HI; the setting word is latched.
- WT_HI: captured word goes to tx_data_o[63:32], then -> RD_LO.
- WT_LO: captured word goes to tx_data_o[31:0], then -> WT_TXIDLE.

REQ-008 WT_TXIDLE -> SEND on the first cycle tx_busy_i=0.

REQ-009 SEND:
- tx_send_o=1 for exactly one cycle.
- tx_data_o and tx_dlc_o are stable from SEND until the next RD_HI.
- Then -> WT_TXBUSY.

REQ-010 Transmitter wait:
- WT_TXBUSY -> WT_TXDONE when tx_busy_i=1.
- WT_TXDONE -> CLR when tx_busy_i=0.

REQ-011 CLR:
- Assert wr_en for one cycle, only when wr_busy=0.
- addr_wr = ADDR_SETTING; data_wr = latched setting word with bit31 cleared.
- WT_CLR -> IDLE on wr_done; frames_sent_o increments by 1, wrapping 0xFFFF -> 0x0000.

REQ-012 Timeouts:
- A single timeout counter restarts on every state entry.
- In any WT_* state or WT_TXIDLE, reaching TIMEOUT_CYCLES sets err_o=1 and returns to IDLE.
- frames_sent_o is unchanged and GO is not cleared, so the frame is retried on the next poll.

REQ-013 Pulse handling:
- rd_done/wr_done arriving outside the matching wait state are ignored.
- rd_done in the same cycle as timeout expiry counts as done; the timeout is not taken.

REQ-014 err_o is cleared only by reset.

REQ-015 Port ownership:
- rd_en and wr_en are never high together.
- At most one outstanding memory request at any time.

Reset
REQ-016 While rst_i=1, asynchronously:
- State=IDLE; poll and timeout counters = 0.
- rd_en=0, wr_en=0, tx_send_o=0, busy_o=0, err_o=0.
- addr_rd=0, addr_wr=0, data_wr=0, tx_data_o=0, tx_dlc_o=0, frames_sent_o=0.

REQ-017 Reset mid-operation abandons the transfer with no further request pulses. Memory contents are untouched, so a pending GO is re-serviced after reset.

Verification
REQ-018 Required directed scenarios:
- Nominal frame: setting=0x80000008, data words 0x31323334 then 0x35363738 -> tx_data_o=0x3132333435363738, tx_dlc_o=8, one tx_send_o pulse; write to 0xA0002 with data 0x00000008; frames_sent_o=1.
- GO clear: setting=0x00000008 -> no rd_en to 0xA0001, no tx_send_o, returns to IDLE and polls again after POLL_CYCLES.
- DLC saturation: setting=0x8000000F -> tx_dlc_o=8; write-back data=0x0000000F.
- Backpressure: rd_busy held high 50 cycles, tx_busy_i high at SEND entry for 20 cycles -> rd_en delayed until rd_busy=0; tx_send_o asserted only after tx_busy_i falls; exactly one pulse each.
- Timeout: rd_done withheld in WT_HI -> err_o=1 after TIMEOUT_CYCLES, return to IDLE, no write; the next poll completes the frame with err_o still 1.
- Reset in WT_TXDONE -> all outputs at reset values next edge; after release the frame resends once and frames_sent_o=1.
